// File: rtl/decoder.sv
// Binary-to-one-hot decoder with enable and a registered output stage.
// Drives one of N select lines high one clock after the index is sampled.
// Indices at or above N (only reachable when N is not a power of two) raise err.
module decoder #(
  parameter int unsigned N   = 64,
  parameter int unsigned A_W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [A_W-1:0] a,
  output logic [N-1:0]   y,
  output logic           valid,
  output logic           err
);

  logic           in_range;
  logic [N-1:0]   y_d, y_q;
  logic           valid_d, valid_q;
  logic           err_d, err_q;

  // When N fills the index space every index is legal; otherwise compare against N.
  if (N == (2 ** A_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_partial_range
    localparam logic [A_W-1:0] NumLines = A_W'(N);
    assign in_range = (a < NumLines);
  end

  // Next-state decode; a is not consulted at all while disabled.
  always_comb begin
    y_d     = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (enable) begin
      if (in_range) begin
        y_d     = {{(N-1){1'b0}}, 1'b1} << a;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Output register with synchronous active-low reset overriding the decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder: a 64-line instance for the main
// behaviour and a 48-line instance for out-of-range index handling.
module tb_decoder;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [5:0]  a;
  logic [63:0] y64;
  logic        valid64, err64;
  logic [47:0] y48;
  logic        valid48, err48;

  int checks;
  int failures;

  decoder #(.N(64)) u_dut64 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .a      (a),
    .y      (y64),
    .valid  (valid64),
    .err    (err64)
  );

  decoder #(.N(48)) u_dut48 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .a      (a),
    .y      (y48),
    .valid  (valid48),
    .err    (err48)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    a      = 6'd5;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (y64 !== 64'h0 || valid64 !== 1'b0 || err64 !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: y=%h valid=%b err=%b, need y=0 valid=0 err=0",
                 i, y64, valid64, err64);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (y64 !== 64'h20 || valid64 !== 1'b1 || err64 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: y=%h valid=%b err=%b, need y=20 valid=1 err=0",
               y64, valid64, err64);
    end
  endtask

  task automatic test_disabled();
    enable = 1'b0;
    for (int i = 0; i <= 64; i++) begin
      a = (i == 64) ? 6'bx : 6'(i);
      step();
      checks++;
      if (y64 !== 64'h0 || valid64 !== 1'b0 || err64 !== 1'b0) begin
        failures++;
        $display("FAIL disabled a=%0d: y=%h valid=%b err=%b, need all zero",
                 i, y64, valid64, err64);
      end
    end
  endtask

  // Full index sweep; optionally pulses reset for one cycle at a=20.
  task automatic test_sweep(input bit reset_mid);
    logic [63:0] exp_y;
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      rst_n = !(reset_mid && i == 20);
      step();
      checks++;
      if (!rst_n) begin
        if (y64 !== 64'h0 || valid64 !== 1'b0 || err64 !== 1'b0) begin
          failures++;
          $display("FAIL sweep_mid_reset: y=%h valid=%b err=%b, need all zero",
                   y64, valid64, err64);
        end
      end else begin
        exp_y = 64'd1 << i;
        if (y64 !== exp_y || valid64 !== 1'b1 || err64 !== 1'b0 || $countones(y64) != 1) begin
          failures++;
          $display("FAIL sweep a=%0d: y=%h valid=%b err=%b, need y=%h valid=1 err=0",
                   i, y64, valid64, err64, exp_y);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_enable_toggle();
    logic [63:0] exp_y [3];
    logic        en_seq [3];
    en_seq[0] = 1'b1; en_seq[1] = 1'b0; en_seq[2] = 1'b1;
    exp_y[0] = 64'h400; exp_y[1] = 64'h0; exp_y[2] = 64'h400;
    a = 6'd10;
    for (int i = 0; i < 3; i++) begin
      enable = en_seq[i];
      step();
      checks++;
      if (y64 !== exp_y[i] || valid64 !== en_seq[i] || err64 !== 1'b0) begin
        failures++;
        $display("FAIL enable_toggle step %0d: y=%h valid=%b err=%b, need y=%h valid=%b err=0",
                 i, y64, valid64, err64, exp_y[i], en_seq[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    enable = 1'b1;
    a = 6'd47;
    step();
    checks++;
    if (y48 !== 48'h8000_0000_0000 || valid48 !== 1'b1 || err48 !== 1'b0) begin
      failures++;
      $display("FAIL oor_a47: y=%h valid=%b err=%b, need y=800000000000 valid=1 err=0",
               y48, valid48, err48);
    end
    a = 6'd50;
    step();
    checks++;
    if (y48 !== 48'h0 || valid48 !== 1'b0 || err48 !== 1'b1) begin
      failures++;
      $display("FAIL oor_a50: y=%h valid=%b err=%b, need y=0 valid=0 err=1",
               y48, valid48, err48);
    end
    checks++;
    if (y64 !== 64'h0004_0000_0000_0000 || valid64 !== 1'b1 || err64 !== 1'b0) begin
      failures++;
      $display("FAIL oor_a50_n64: y=%h valid=%b err=%b, need y=4000000000000 valid=1 err=0",
               y64, valid64, err64);
    end
    a = 6'd63;
    step();
    checks++;
    if (y48 !== 48'h0 || valid48 !== 1'b0 || err48 !== 1'b1) begin
      failures++;
      $display("FAIL oor_a63: y=%h valid=%b err=%b, need y=0 valid=0 err=1",
               y48, valid48, err48);
    end
    enable = 1'b0;
    step();
    checks++;
    if (y48 !== 48'h0 || valid48 !== 1'b0 || err48 !== 1'b0) begin
      failures++;
      $display("FAIL oor_disable: y=%h valid=%b err=%b, need all zero", y48, valid48, err48);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq [6];
    logic [63:0] exp_y;
    seq[0] = 6'd0; seq[1] = 6'd63; seq[2] = 6'd1; seq[3] = 6'd62; seq[4] = 6'd31; seq[5] = 6'd32;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = seq[i];
      step();
      exp_y = 64'd1 << seq[i];
      checks++;
      if (y64 !== exp_y || valid64 !== 1'b1 || err64 !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back a=%0d: y=%h valid=%b, need y=%h valid=1",
                 seq[i], y64, valid64, exp_y);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    a        = '0;
    test_reset();
    test_disabled();
    test_sweep(1'b0);
    test_enable_toggle();
    test_out_of_range();
    test_sweep(1'b1);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
